rggen_register_access_controller: RTL and testbench

//  Sequences one host access at a time onto the register block: latches the host command,

---
 rtl/rggen_register_access_controller.sv | 144 ++++++++++++++
 tb/tb_rggen_register_access_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_register_access_controller.sv
// Host-to-register-block access sequencer: one command at a time, IDLE -> ACCESS -> RESPONSE.
// Ports: command (valid/ready, addr, write, wdata), response (valid/ready, status, rdata),
//        register side (valid, write, addr, wdata out; select, ready, packed read data in).
module rggen_register_access_controller #(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_command_valid,
  output logic                                  o_command_ready,
  input  logic [ADDRESS_WIDTH-1:0]              i_command_address,
  input  logic                                  i_command_write,
  input  logic [DATA_WIDTH-1:0]                 i_command_write_data,
  output logic                                  o_response_valid,
  input  logic                                  i_response_ready,
  output logic [1:0]                            o_response_status,
  output logic [DATA_WIDTH-1:0]                 o_response_read_data,
  output logic                                  o_register_valid,
  output logic                                  o_register_write,
  output logic [ADDRESS_WIDTH-1:0]              o_register_address,
  output logic [DATA_WIDTH-1:0]                 o_register_write_data,
  input  logic [TOTAL_REGISTERS-1:0]            i_register_select,
  input  logic [TOTAL_REGISTERS-1:0]            i_register_ready,
  input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_register_read_data
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPONSE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [1:0]              status_q, status_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    sel_one_hot;
  logic                    sel_ready;
  logic                    timeout;
  logic [DATA_WIDTH-1:0]   sel_data;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < TOTAL_REGISTERS; i++) begin
      if (i_register_select[i]) begin
        sel_data = i_register_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sel_one_hot = $onehot(i_register_select);
  // Only the selected register's ready counts.
  assign sel_ready   = |(i_register_select & i_register_ready);
  // timer_q holds completed ACCESS cycles, so this is the last allowed cycle.
  assign timeout     = timer_q >= TW'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    timer_d  = timer_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_command_valid) begin
          addr_d  = i_command_address;
          write_d = i_command_write;
          wdata_d = i_command_write_data;
          timer_d = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (timer_q != TW'(TIMEOUT_CYCLES)) begin
          timer_d = timer_q + TW'(1);
        end
        if (!sel_one_hot) begin
          status_d = DECERR;
          rdata_d  = '0;
          state_d  = RESPONSE;
        end else if (sel_ready) begin
          status_d = OKAY;
          rdata_d  = write_q ? '0 : sel_data;
          state_d  = RESPONSE;
        end else if (timeout) begin
          status_d = SLVERR;
          rdata_d  = '0;
          state_d  = RESPONSE;
        end
      end
      RESPONSE: begin
        if (i_response_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      timer_q  <= '0;
      status_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      timer_q  <= timer_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_command_ready       = state_q == IDLE;
  assign o_register_valid      = state_q == ACCESS;
  assign o_register_write      = write_q;
  assign o_register_address    = addr_q;
  assign o_register_write_data = wdata_q;
  assign o_response_valid      = state_q == RESPONSE;
  assign o_response_status     = (state_q == RESPONSE) ? status_q : 2'b00;
  assign o_response_read_data  = (state_q == RESPONSE) ? rdata_q : '0;

endmodule

// File: tb/tb_rggen_register_access_controller.sv
// Bench for rggen_register_access_controller: directed commands, scoreboard-checked responses.
// Register array is modelled by an address decoder plus a configurable ready delay.
module tb_rggen_register_access_controller;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr = '0;
  logic            cmd_write = 1'b0;
  logic [DW-1:0]   cmd_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_status;
  logic [DW-1:0]   rsp_data;
  logic            reg_valid;
  logic            reg_write;
  logic [AW-1:0]   reg_addr;
  logic [DW-1:0]   reg_wdata;
  logic [NR-1:0]   reg_sel;
  logic [NR-1:0]   reg_ready;
  logic [NR*DW-1:0] reg_rdata;

  logic            force_en = 1'b0;
  logic [NR-1:0]   force_sel = '0;
  logic            noise_en = 1'b0;
  int              ready_after = 1;
  int              acc_cyc = 0;
  logic [NR-1:0]   dec;

  typedef struct packed {
    logic [1:0]    status;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int mtests = 0;
  int mfails = 0;

  always #5 clk = ~clk;

  rggen_register_access_controller #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TOTAL_REGISTERS(NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_command_valid(cmd_valid),
    .o_command_ready(cmd_ready),
    .i_command_address(cmd_addr),
    .i_command_write(cmd_write),
    .i_command_write_data(cmd_wdata),
    .o_response_valid(rsp_valid),
    .i_response_ready(rsp_ready),
    .o_response_status(rsp_status),
    .o_response_read_data(rsp_data),
    .o_register_valid(reg_valid),
    .o_register_write(reg_write),
    .o_register_address(reg_addr),
    .o_register_write_data(reg_wdata),
    .i_register_select(reg_sel),
    .i_register_ready(reg_ready),
    .i_register_read_data(reg_rdata)
  );

  assign reg_rdata = {32'hA000_0003, 32'hA000_0002, 32'hDEAD_BEEF, 32'hA000_0000};
  assign dec = (reg_addr[15:4] == 12'h0) ? (4'b0001 << reg_addr[3:2]) : 4'b0000;
  assign reg_sel = force_en ? force_sel : dec;
  assign reg_ready = (noise_en ? ~reg_sel : 4'b0000) |
                     ((reg_valid && ready_after != 0 && acc_cyc + 1 == ready_after)
                      ? reg_sel : 4'b0000);

  always @(posedge clk) begin
    if (reg_valid) acc_cyc <= acc_cyc + 1;
    else acc_cyc <= 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid && rsp_ready) begin
      mtests++;
      if (q.size() == 0) begin
        mfails++;
        $display("FAIL rsp_unexpected: got %b/%h, none expected", rsp_status, rsp_data);
      end else begin
        e = q.pop_front();
        if (rsp_status !== e.status || rsp_data !== e.data) begin
          mfails++;
          $display("FAIL rsp: got %b/%h, want %b/%h", rsp_status, rsp_data, e.status, e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic do_cmd(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                        input logic [1:0] st, input logic [DW-1:0] rd,
                        input int vcyc, input int hold);
    int n;
    int vc;
    bit bad_wd;
    exp_t e;
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    e.status = st;
    e.data   = rd;
    q.push_back(e);
    n = 0;
    vc = 0;
    bad_wd = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      if (reg_valid) begin
        vc++;
        if (reg_wdata !== d || reg_write !== w) bad_wd = 1;
      end
      n++;
      if (n > 50) begin
        chk("rsp_timeout", 64'd0, 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests + mtests, fails + mfails);
        $fatal(1, "no response");
      end
    end
    chk("latency", 64'(n + 1), 64'(vcyc + 1));
    chk("reg_valid_cycles", 64'(vc), 64'(vcyc));
    chk("reg_wdata_stable", 64'(bad_wd), 64'd0);
    for (int i = 0; i < hold; i++) begin
      chk("bp_status", {62'd0, rsp_status}, {62'd0, st});
      chk("bp_data", 64'(rsp_data), 64'(rd));
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("back_idle", {62'd0, cmd_ready, rsp_valid}, 64'b10);
  endtask

  initial begin
    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_outs", {59'd0, rsp_valid, rsp_status, reg_valid, reg_write}, 64'd0);
    chk("rst_addr", 64'(reg_addr), 64'd0);
    chk("rst_data", {rsp_data, reg_wdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    ready_after = 1;
    do_cmd(16'h0004, 1'b0, 32'h0, 2'b00, 32'hDEAD_BEEF, 1, 0);

    ready_after = 3;
    do_cmd(16'h0008, 1'b1, 32'h1234_5678, 2'b00, 32'h0, 3, 0);

    ready_after = 1;
    do_cmd(16'h0100, 1'b1, 32'hCAFE_0001, 2'b11, 32'h0, 1, 0);

    force_en = 1'b1;
    force_sel = 4'b0110;
    do_cmd(16'h0004, 1'b0, 32'h0, 2'b11, 32'h0, 1, 0);
    force_en = 1'b0;

    ready_after = 0;
    noise_en = 1'b1;
    do_cmd(16'h0004, 1'b0, 32'h0, 2'b10, 32'h0, TO, 0);
    noise_en = 1'b0;

    ready_after = TO;
    do_cmd(16'h000C, 1'b0, 32'h0, 2'b00, 32'hA000_0003, TO, 0);

    ready_after = 2;
    do_cmd(16'h0000, 1'b0, 32'h0, 2'b00, 32'hA000_0000, 2, 5);

    ready_after = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 16'h0008;
    cmd_write = 1'b1;
    cmd_wdata = 32'h5555_AAAA;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_access", 64'(reg_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {61'd0, reg_valid, rsp_valid, cmd_ready}, 64'b001);
    chk("arst_latched", {reg_addr, reg_write, 15'd0, reg_wdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ready_after = 1;
    do_cmd(16'h0004, 1'b0, 32'h0, 2'b00, 32'hDEAD_BEEF, 1, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests + mtests, fails + mfails);
    $finish;
  end

endmodule
